// File: rtl/dispatch_queue.sv
// In-order decoupling FIFO between the ID/EX register and rename/issue.
// Bubble bundles (opcode 0) are counted and discarded instead of being stored.
module dispatch_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 70
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_bundle,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_bundle,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          accept;
    logic          bubble;
    logic          store;
    logic          deq;

    always_comb begin
        full      = (count == CW'(DEPTH));
        in_ready  = ~full;
        out_valid = (count != '0);
        accept    = in_valid & in_ready & ~flush;
        bubble    = (in_bundle[69:63] == 7'd0);
        store     = accept & ~bubble;
        deq       = out_valid & out_ready & ~flush;
        out_bundle = out_valid ? mem[rd_ptr] : '0;
    end

    // Flush only rewinds pointers and count; stale storage is never visible
    // because out_bundle is masked whenever the queue is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) begin
                mem[wr_ptr] <= in_bundle;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (accept && bubble) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(store) - CW'(deq);
        end
    end
endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_dispatch_queue;
    localparam int DEPTH = 4;
    localparam int W     = 70;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_bundle = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_bundle;
    logic [2:0]    count;
    logic [15:0]   drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    dispatch_queue #(.DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_bundle(in_bundle),
        .out_valid(out_valid), .out_ready(out_ready), .out_bundle(out_bundle),
        .count(count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored bundles plus a bubble counter.
    logic [W-1:0] mq[$];
    logic [15:0]  mdrop = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mdrop = '0;
        end else if (flush) begin
            mq.delete();
        end else begin
            automatic bit acc = in_valid && (mq.size() < DEPTH);
            automatic bit pop = out_ready && (mq.size() > 0);
            if (pop) void'(mq.pop_front());
            if (acc) begin
                if (in_bundle[69:63] != 7'd0) mq.push_back(in_bundle);
                else mdrop = mdrop + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        automatic logic [W-1:0] head = (mq.size() > 0) ? mq[0] : '0;
        check("out_valid", W'(out_valid), W'(mq.size() > 0));
        check("out_bundle", out_bundle, head);
        check("in_ready", W'(in_ready), W'(mq.size() < DEPTH));
        check("count", W'(count), W'(mq.size()));
        check("drop_cnt", W'(drop_cnt), W'(mdrop));
    end

    function automatic logic [W-1:0] mk(input logic [6:0] op, input logic [31:0] imm);
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        r[69:63] = op;
        r[37:6]  = imm;
        return r[W-1:0];
    endfunction

    // Apply inputs, then return 1 time unit after the edge that samples them.
    task automatic drive(input logic v, input logic [W-1:0] b, input logic ordy, input logic fl);
        in_valid  = v;
        in_bundle = b;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] ops [4];
        logic [W-1:0] b;
        ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_count", W'(count), W'(0));
        check("reset_in_ready", W'(in_ready), W'(1));

        // Fill then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mk(ops[i], $urandom), 1'b0, 1'b0);
            check("fill_count", W'(count), W'(i + 1));
        end
        check("full_in_ready", W'(in_ready), W'(0));
        drive(1'b1, mk(7'h07, $urandom), 1'b0, 1'b0);
        check("fifth_rejected", W'(count), W'(4));
        for (int i = 0; i < 4; i++) begin
            check("drain_order", W'(out_bundle[69:63]), W'(ops[i]));
            drive(1'b0, '0, 1'b1, 1'b0);
        end
        check("drained_valid", W'(out_valid), W'(0));
        check("drained_bundle", out_bundle, '0);

        // Bubble drop
        reset_pulse();
        drive(1'b1, mk(7'h00, $urandom), 1'b0, 1'b0);
        drive(1'b1, mk(7'h33, 32'hDEADBEEF), 1'b0, 1'b0);
        check("bubble_drop_cnt", W'(drop_cnt), W'(1));
        check("bubble_count", W'(count), W'(1));
        check("bubble_imm", W'(out_bundle[37:6]), W'(32'hDEADBEEF));

        // Steady-state enqueue+dequeue at count=2, pointers wrap
        reset_pulse();
        drive(1'b1, mk(7'h33, 32'd100), 1'b0, 1'b0);
        drive(1'b1, mk(7'h33, 32'd101), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("stream_head_imm", W'(out_bundle[37:6]), W'(100 + i));
            drive(1'b1, mk(7'h13, 32'(102 + i)), 1'b1, 1'b0);
            check("stream_count", W'(count), W'(2));
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Flush with concurrent enqueue and dequeue
        for (int i = 0; i < 3; i++) drive(1'b1, mk(7'h23, $urandom), 1'b0, 1'b0);
        check("preflush_count", W'(count), W'(3));
        drive(1'b1, mk(7'h33, $urandom), 1'b1, 1'b1);
        check("flush_count", W'(count), W'(0));
        check("flush_valid", W'(out_valid), W'(0));
        drive(1'b1, mk(7'h13, 32'h12345678), 1'b0, 1'b0);
        check("postflush_count", W'(count), W'(1));
        check("postflush_imm", W'(out_bundle[37:6]), W'(32'h12345678));

        // Full with out_ready: dequeue only, enqueue on the next cycle
        reset_pulse();
        for (int i = 0; i < 4; i++) drive(1'b1, mk(ops[i], $urandom), 1'b0, 1'b0);
        b = mk(7'h03, 32'hCAFEF00D);
        drive(1'b1, b, 1'b1, 1'b0);
        check("full_ordy_count", W'(count), W'(3));
        check("full_ordy_head", W'(out_bundle[69:63]), W'(7'h13));
        drive(1'b1, b, 1'b0, 1'b0);
        check("full_ordy_refill", W'(count), W'(4));

        // Asynchronous reset mid-operation
        reset_pulse();
        drive(1'b1, mk(7'h00, $urandom), 1'b0, 1'b0);
        drive(1'b1, mk(7'h33, $urandom), 1'b0, 1'b0);
        drive(1'b1, mk(7'h13, $urandom), 1'b0, 1'b0);
        check("prereset_count", W'(count), W'(2));
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", W'(out_valid), W'(0));
        check("async_rst_bundle", out_bundle, '0);
        check("async_rst_in_ready", W'(in_ready), W'(1));
        check("async_rst_count", W'(count), W'(0));
        check("async_rst_drop", W'(drop_cnt), W'(0));
        drive(1'b1, mk(7'h33, $urandom), 1'b1, 1'b0);
        check("rst_held_count", W'(count), W'(0));
        check("rst_held_valid", W'(out_valid), W'(0));
        rst = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            automatic logic [6:0] op = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom_range(1, 127));
            rst = ($urandom_range(0, 299) == 0);
            drive(1'($urandom_range(0, 3) != 0), mk(op, $urandom),
                  1'($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
        end
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
